// File: rtl/one_byte_uart_rx.sv
// 8N1 UART receiver: oversampled line, start-bit glitch rejection, mid-bit sampling, stop-bit check.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop, reported on parity_err.
module one_byte_uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              rx_meta, rx_s, rx_d;
  logic [DIV_W-1:0]  div_cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic              par_q;
  logic              par_bad;
  logic              start_edge, os_tick;
  logic              start_go, samp, shift_en, par_en, clr_bits;
  logic              valid_nxt, ferr_nxt, perr_nxt;

  assign start_edge = rx_d & ~rx_s;
  assign os_tick    = (div_cnt == DIV_LAST);
  assign busy       = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    samp      = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    clr_bits  = 1'b0;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_nxt = ST_START;
          start_go  = 1'b1;
        end
      end
      ST_START: begin
        // Mid start bit: a high line here means the falling edge was a glitch
        if (os_tick && os_cnt == OS_HALF) begin
          samp      = 1'b1;
          clr_bits  = 1'b1;
          state_nxt = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (os_tick && os_cnt == OS_LAST) begin
          samp     = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (os_tick && os_cnt == OS_LAST) begin
          samp      = 1'b1;
          par_en    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Return to IDLE at mid stop bit so a back-to-back start edge is not missed
        if (os_tick && os_cnt == OS_LAST) begin
          samp      = 1'b1;
          valid_nxt = rx_s & ~par_bad;
          ferr_nxt  = ~rx_s;
          perr_nxt  = par_bad;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      div_cnt   <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;

      if (start_go || os_tick) div_cnt <= '0;
      else                     div_cnt <= div_cnt + 1'b1;

      if (start_go || samp || state == ST_IDLE) os_cnt <= '0;
      else if (os_tick)                         os_cnt <= os_cnt + 1'b1;

      if (clr_bits)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
      if (par_en)   par_q   <= rx_s;

      if (valid_nxt) rx_data <= shift_q;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= perr_nxt;
  end
`else
  logic unused_perr;
  assign unused_perr = perr_nxt ^ par_en ^ par_q;
`endif

endmodule
